// File: rtl/bcd_to_bin_if.sv
// Handshake/data bundle for the iterative BCD-to-binary converter.
// The err signal exists only when BCD_ERR_CHK_EN is defined.
interface bcd_to_bin_if #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 16
);
    logic                  start;
    logic [4*N_DIGITS-1:0] bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin;
`ifdef BCD_ERR_CHK_EN
    logic                  err;
`endif

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin
`ifdef BCD_ERR_CHK_EN
        ,
        input  err
`endif
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin
`ifdef BCD_ERR_CHK_EN
        ,
        output err
`endif
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional macro BCD_ERR_CHK_EN adds input digit validation and the err output.
module bcd_to_bin #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    bcd_to_bin_if.slave      bus
);
    localparam int WORK_W = 4*N_DIGITS + BIN_W;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WORK_W-1:0] work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [WORK_W-1:0] shifted, corrected;
    logic [3:0]        digit;
`ifdef BCD_ERR_CHK_EN
    logic              err_q, err_d;
    logic              bad_input;
    logic [3:0]        in_digit;
`endif

    // One dabble step: shift right, then pull every BCD digit >= 8 back by 3.
    always_comb begin
        shifted   = work_q >> 1;
        corrected = shifted;
        digit     = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            digit = shifted[BIN_W + 4*i +: 4];
            if (digit >= 4'd8) begin
                corrected[BIN_W + 4*i +: 4] = digit - 4'd3;
            end
        end
    end

`ifdef BCD_ERR_CHK_EN
    always_comb begin
        bad_input = 1'b0;
        in_digit  = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            in_digit = bus.bcd_in[4*i +: 4];
            if (in_digit > 4'd9) begin
                bad_input = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
`ifdef BCD_ERR_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start exactly like IDLE so conversions can run back to back.
                if (bus.start) begin
`ifdef BCD_ERR_CHK_EN
                    if (bad_input) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        bin_d   = '0;
                    end else begin
                        work_d  = {bus.bcd_in, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        state_d = CONV;
                    end
`else
                    work_d  = {bus.bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = CONV;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                work_d = corrected;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bin_d   = corrected[BIN_W-1:0];
                    state_d = DONE;
`ifdef BCD_ERR_CHK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
`ifdef BCD_ERR_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
`ifdef BCD_ERR_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.busy = (state_q == CONV);
    assign bus.done = (state_q == DONE);
    assign bus.bin  = bin_q;
`ifdef BCD_ERR_CHK_EN
    assign bus.err  = err_q;
`endif
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (default 4 digits / 16-bit result).
// The error-check scenario is included when BCD_ERR_CHK_EN is defined.
module tb_bcd_to_bin;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    bcd_to_bin_if #(.N_DIGITS(4), .BIN_W(16)) bus ();

    bcd_to_bin #(.N_DIGITS(4), .BIN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns at the falling edge after the load edge.
    task automatic start_conv(input logic [15:0] v);
        @(negedge clk);
        bus.bcd_in = v;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Counts rising edges until done is seen; 99 means it never arrived.
    task automatic wait_done(output int edges);
        edges = 99;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = 16'h0000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++;
        if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
        n_cmp++;
        if (bus.bin !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_bin got %h want 0000", bus.bin); end
`ifdef BCD_ERR_CHK_EN
        n_cmp++;
        if (bus.err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0", bus.err); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int busy_cycles;
        int edges;
        start_conv(16'h0000);
        busy_cycles = 0;
        edges       = 99;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                edges = k;
                break;
            end
        end
        n_cmp++;
        if (edges != 16) begin n_fail++; $display("[TB] FAIL zero_latency got %0d want 16", edges); end
        n_cmp++;
        if (busy_cycles != 16) begin n_fail++; $display("[TB] FAIL zero_busy_cycles got %0d want 16", busy_cycles); end
        n_cmp++;
        if (bus.bin !== 16'd0) begin n_fail++; $display("[TB] FAIL zero_bin got %h want 0000", bus.bin); end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_convert();
        int edges;
        start_conv(16'h1234);
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL conv_busy got %b want 1", bus.busy); end
        wait_done(edges);
        n_cmp++;
        if (edges != 16) begin n_fail++; $display("[TB] FAIL conv_latency got %0d want 16", edges); end
        n_cmp++;
        if (bus.bin !== 16'h04D2) begin n_fail++; $display("[TB] FAIL conv_bin got %h want 04d2", bus.bin); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL conv_busy_at_done got %b want 0", bus.busy); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int edges;
        start_conv(16'h9999);
        wait_done(edges);
        n_cmp++;
        if (bus.bin !== 16'h270F) begin n_fail++; $display("[TB] FAIL b2b_first_bin got %h want 270f", bus.bin); end
        // Still in the DONE cycle: request the next conversion immediately.
        bus.bcd_in = 16'h0042;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_restart_busy got %b want 1", bus.busy); end
        n_cmp++;
        if (bus.bin !== 16'h270F) begin n_fail++; $display("[TB] FAIL b2b_bin_held got %h want 270f", bus.bin); end
        wait_done(edges);
        n_cmp++;
        if (edges != 16) begin n_fail++; $display("[TB] FAIL b2b_latency got %0d want 16", edges); end
        n_cmp++;
        if (bus.bin !== 16'h002A) begin n_fail++; $display("[TB] FAIL b2b_second_bin got %h want 002a", bus.bin); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int edges;
        start_conv(16'h0500);
        repeat (4) @(negedge clk);
        bus.bcd_in = 16'h0007;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(edges);
        n_cmp++;
        if (edges + 5 != 16) begin n_fail++; $display("[TB] FAIL ignore_latency got %0d want 16", edges + 5); end
        n_cmp++;
        if (bus.bin !== 16'h01F4) begin n_fail++; $display("[TB] FAIL ignore_bin got %h want 01f4", bus.bin); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int edges;
        start_conv(16'h0808);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #2;
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
        n_cmp++;
        if (bus.bin !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_bin got %h want 0000", bus.bin); end
        @(negedge clk);
        rst = 1'b0;
        wait_done(edges);
        n_cmp++;
        if (edges != 99) begin n_fail++; $display("[TB] FAIL abort_no_done got %0d want 99", edges); end
        start_conv(16'h0808);
        wait_done(edges);
        n_cmp++;
        if (edges != 16) begin n_fail++; $display("[TB] FAIL abort_restart_latency got %0d want 16", edges); end
        n_cmp++;
        if (bus.bin !== 16'h0328) begin n_fail++; $display("[TB] FAIL abort_restart_bin got %h want 0328", bus.bin); end
        @(negedge clk);
    endtask

`ifdef BCD_ERR_CHK_EN
    task automatic test_err_check();
        int edges;
        start_conv(16'h12A4);
        n_cmp++;
        if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL err_done_fast got %b want 1", bus.done); end
        n_cmp++;
        if (bus.err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_flag got %b want 1", bus.err); end
        n_cmp++;
        if (bus.bin !== 16'h0000) begin n_fail++; $display("[TB] FAIL err_bin got %h want 0000", bus.bin); end
        @(negedge clk);
        n_cmp++;
        if (bus.err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_held got %b want 1", bus.err); end
        start_conv(16'h0010);
        wait_done(edges);
        n_cmp++;
        if (edges != 16) begin n_fail++; $display("[TB] FAIL err_valid_latency got %0d want 16", edges); end
        n_cmp++;
        if (bus.err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear got %b want 0", bus.err); end
        n_cmp++;
        if (bus.bin !== 16'h000A) begin n_fail++; $display("[TB] FAIL err_valid_bin got %h want 000a", bus.bin); end
        @(negedge clk);
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_zero();
        test_convert();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
`ifdef BCD_ERR_CHK_EN
        test_err_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
